// File: rtl/vscale_dmem_arbiter.sv
// Round-robin arbiter sharing one split-phase data-memory port among NUM_CORES vscale
// pipelines; ungranted requests wait in per-core buffers, faulting accesses never reach memory.
`timescale 1ns/1ps
module vscale_dmem_arbiter #(
    parameter int unsigned NUM_CORES      = 4,
    parameter int unsigned XPR_LEN        = 32,
    parameter int unsigned MEM_TYPE_WIDTH = 3,
    parameter int unsigned MEM_SIZE_BYTES = 32'h10000
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CORES-1:0]                core_dmem_en,
    input  logic [NUM_CORES-1:0]                core_dmem_wen,
    input  logic [NUM_CORES*MEM_TYPE_WIDTH-1:0] core_dmem_size,
    input  logic [NUM_CORES*XPR_LEN-1:0]        core_dmem_addr,
    input  logic [NUM_CORES*XPR_LEN-1:0]        core_dmem_wdata,
    output logic [XPR_LEN-1:0]                  core_dmem_rdata,
    output logic [NUM_CORES-1:0]                core_dmem_wait,
    output logic [NUM_CORES-1:0]                core_dmem_badmem_e,
    output logic                                mem_en,
    output logic                                mem_wen,
    output logic [MEM_TYPE_WIDTH-1:0]           mem_size,
    output logic [XPR_LEN-1:0]                  mem_addr,
    output logic [2:0]                          mem_core_id,
    output logic [XPR_LEN-1:0]                  mem_wdata,
    input  logic [XPR_LEN-1:0]                  mem_rdata,
    input  logic                                mem_wait
);
    localparam int unsigned IdW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [XPR_LEN:0] MemLimit = (XPR_LEN+1)'(MEM_SIZE_BYTES);

    typedef enum logic [1:0] {StIdle, StPending, StData} core_state_e;

    core_state_e               r_state      [NUM_CORES];
    core_state_e               w_state_next [NUM_CORES];
    logic [NUM_CORES-1:0]      r_buf_wen;
    logic [MEM_TYPE_WIDTH-1:0] r_buf_size   [NUM_CORES];
    logic [XPR_LEN-1:0]        r_buf_addr   [NUM_CORES];
    logic [IdW-1:0]            r_last_grant;
    logic [IdW-1:0]            r_owner_id;
    logic                      r_owner_valid;
    logic                      r_owner_bad;

    logic                      w_stall;
    logic                      w_owner_done;
    logic                      w_grant;
    logic [IdW-1:0]            w_win_id;
    logic [NUM_CORES-1:0]      w_live;
    logic [NUM_CORES-1:0]      w_elig;
    logic [NUM_CORES-1:0]      w_latch;
    logic                      w_sel_wen;
    logic [MEM_TYPE_WIDTH-1:0] w_sel_size;
    logic [XPR_LEN-1:0]        w_sel_addr;
    logic                      w_sel_bad;

    function automatic logic is_fault(input logic [XPR_LEN-1:0] addr, input logic [1:0] size_lo);
        logic misaligned;
        misaligned = 1'b0;
        if (size_lo == 2'd1) begin
            misaligned = addr[0];
        end else if (size_lo == 2'd2) begin
            misaligned = |addr[1:0];
        end
        return misaligned || ({1'b0, addr} >= MemLimit);
    endfunction

    // A faulting data phase never stalls: mem_wait is ignored for it.
    assign w_stall      = r_owner_valid && !r_owner_bad && mem_wait;
    assign w_owner_done = r_owner_valid && !w_stall;

    always_comb begin
        w_live = '0;
        w_elig = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_live[i] = core_dmem_en[i] &&
                        ((r_state[i] == StIdle) || (r_state[i] == StData && w_owner_done));
            w_elig[i] = w_live[i] || (r_state[i] == StPending);
        end
    end

    always_comb begin
        logic [IdW-1:0] w_idx;
        w_idx    = '0;
        w_grant  = 1'b0;
        w_win_id = '0;
        if (!reset && !w_stall) begin
            for (int unsigned k = 1; k <= NUM_CORES; k++) begin
                w_idx = IdW'((32'(r_last_grant) + k) % NUM_CORES);
                if (!w_grant && w_elig[w_idx]) begin
                    w_grant  = 1'b1;
                    w_win_id = w_idx;
                end
            end
        end
    end

    // A pending winner replays its latched request; a live winner passes straight through.
    always_comb begin
        w_sel_wen  = 1'b0;
        w_sel_size = '0;
        w_sel_addr = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_win_id == IdW'(i)) begin
                if (r_state[i] == StPending) begin
                    w_sel_wen  = r_buf_wen[i];
                    w_sel_size = r_buf_size[i];
                    w_sel_addr = r_buf_addr[i];
                end else begin
                    w_sel_wen  = core_dmem_wen[i];
                    w_sel_size = core_dmem_size[i*MEM_TYPE_WIDTH +: MEM_TYPE_WIDTH];
                    w_sel_addr = core_dmem_addr[i*XPR_LEN +: XPR_LEN];
                end
            end
        end
        w_sel_bad = is_fault(w_sel_addr, w_sel_size[1:0]);
    end

    assign mem_en          = w_grant && !w_sel_bad;
    assign mem_wen         = w_sel_wen;
    assign mem_size        = w_sel_size;
    assign mem_addr        = w_sel_addr;
    assign mem_core_id     = 3'(w_win_id);
    assign core_dmem_rdata = mem_rdata;

    always_comb begin
        mem_wdata          = '0;
        core_dmem_wait     = '0;
        core_dmem_badmem_e = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (r_owner_id == IdW'(i)) begin
                mem_wdata = core_dmem_wdata[i*XPR_LEN +: XPR_LEN];
            end
            core_dmem_wait[i]     = (r_state[i] == StPending) ||
                                    (r_state[i] == StData && w_stall);
            core_dmem_badmem_e[i] = (r_state[i] == StData) && r_owner_bad;
        end
    end

    always_comb begin
        w_latch = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_state_next[i] = r_state[i];
            w_latch[i]      = w_live[i] && !(w_grant && w_win_id == IdW'(i));
            if (w_grant && w_win_id == IdW'(i)) begin
                w_state_next[i] = StData;
            end else if (w_live[i]) begin
                w_state_next[i] = StPending;
            end else if (r_state[i] == StData && w_owner_done) begin
                w_state_next[i] = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                r_state[i] <= StIdle;
            end
            r_last_grant  <= IdW'(NUM_CORES - 1);
            r_owner_id    <= '0;
            r_owner_valid <= 1'b0;
            r_owner_bad   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                r_state[i] <= w_state_next[i];
            end
            if (w_grant) begin
                r_last_grant  <= w_win_id;
                r_owner_id    <= w_win_id;
                r_owner_valid <= 1'b1;
                r_owner_bad   <= w_sel_bad;
            end else if (w_owner_done) begin
                r_owner_valid <= 1'b0;
                r_owner_bad   <= 1'b0;
            end
        end
    end

    // Buffer contents are only meaningful while the matching core is pending.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_latch[i]) begin
                r_buf_wen[i]  <= core_dmem_wen[i];
                r_buf_size[i] <= core_dmem_size[i*MEM_TYPE_WIDTH +: MEM_TYPE_WIDTH];
                r_buf_addr[i] <= core_dmem_addr[i*XPR_LEN +: XPR_LEN];
            end
        end
    end

endmodule
